// File: rtl/blit_src_reader.sv
// Source-fetch front end of the blitter: walks a source rectangle, issues byte reads with
// credit-based flow control, buffers in-order returns and streams one pixel per cycle.
module blit_src_reader #(
  parameter int ADDR_W     = 26,
  parameter int DIM_W      = 11,
  parameter int STRIDE_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [STRIDE_W-1:0] src_stride,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  input  logic                textmode,
  output logic                busy,
  output logic                done,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic                mem_rvalid,
  input  logic [7:0]          mem_rdata,
  input  logic                stall,
  output logic                out_valid,
  output logic [7:0]          src_data,
  output logic [2:0]          src_bit,
  output logic                out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CREDIT = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, EMPTY} state_t;
  state_t state, state_next;

  logic [DIM_W-1:0]    lat_width, lat_height, bytes_per_row, start_bpr;
  logic                lat_textmode;
  logic [STRIDE_W-1:0] lat_stride;
  logic [ADDR_W-1:0]   row_base, next_addr, stride_ext;
  logic [DIM_W-1:0]    req_col, req_row;
  logic                all_issued;

  logic [CNT_W-1:0]    outstanding, outstanding_next, fifo_count, fifo_count_next;
  logic [CNT_W:0]      credit_sum;
  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [DIM_W-1:0]    out_x, out_y;

  logic accept_start, zero_dims, req_fire, push, pop, load;
  logic row_end, last_pixel, final_out, can_raise;

  always_comb begin
    accept_start     = (state == IDLE) && start;
    zero_dims        = (width == '0) || (height == '0);
    start_bpr        = textmode ? DIM_W'((32'(width) + 32'd7) >> 3) : width;
    stride_ext       = ADDR_W'(lat_stride);
    req_fire         = mem_req && mem_ack;
    push             = mem_rvalid && (outstanding != '0);
    load             = !stall && (fifo_count != '0);
    row_end          = (out_x == lat_width - DIM_W'(1));
    last_pixel       = row_end && (out_y == lat_height - DIM_W'(1));
    pop              = load && (!lat_textmode || (out_x[2:0] == 3'd7) || row_end);
    final_out        = out_valid && out_last && !stall;
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(push);
    fifo_count_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    credit_sum       = {1'b0, fifo_count_next} + {1'b0, outstanding_next};
    // Credit is judged on post-edge counts so a held request is never double-counted
    can_raise        = (state == FETCH) && !all_issued && (!mem_req || mem_ack) &&
                       (credit_sum < CREDIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = zero_dims ? EMPTY : FETCH;
      FETCH:   if (req_fire && all_issued) state_next = DRAIN;
      DRAIN:   if (final_out) state_next = IDLE;
      EMPTY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) done <= 1'b0;
    else          done <= (state != IDLE) && (state_next == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_width     <= '0;
      lat_height    <= '0;
      lat_textmode  <= 1'b0;
      lat_stride    <= '0;
      bytes_per_row <= '0;
      row_base      <= '0;
      next_addr     <= '0;
      req_col       <= '0;
      req_row       <= '0;
      all_issued    <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
    end else if (accept_start) begin
      lat_width     <= width;
      lat_height    <= height;
      lat_textmode  <= textmode;
      lat_stride    <= src_stride;
      bytes_per_row <= start_bpr;
      row_base      <= src_addr;
      next_addr     <= src_addr;
      req_col       <= '0;
      req_row       <= '0;
      all_issued    <= 1'b0;
    end else if (can_raise) begin
      mem_req  <= 1'b1;
      mem_addr <= next_addr;
      if (req_col == bytes_per_row - DIM_W'(1)) begin
        req_col   <= '0;
        req_row   <= req_row + DIM_W'(1);
        row_base  <= row_base + stride_ext;
        next_addr <= row_base + stride_ext;
        if (req_row == lat_height - DIM_W'(1)) all_issued <= 1'b1;
      end else begin
        req_col   <= req_col + DIM_W'(1);
        next_addr <= next_addr + ADDR_W'(1);
      end
    end else if (req_fire) begin
      mem_req <= 1'b0;
    end
  end

  // Returns arriving with nothing outstanding belong to a fetch killed by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_next;
      fifo_count  <= fifo_count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_x     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      src_data  <= '0;
      src_bit   <= '0;
      out_last  <= 1'b0;
    end else if (accept_start) begin
      out_x <= '0;
      out_y <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      src_data  <= fifo_mem[rd_ptr];
      src_bit   <= lat_textmode ? (3'd7 - out_x[2:0]) : 3'd0;
      out_last  <= last_pixel;
      if (row_end) begin
        out_x <= '0;
        out_y <= out_y + DIM_W'(1);
      end else begin
        out_x <= out_x + DIM_W'(1);
      end
    end else if (!stall) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blit_src_reader.sv
// Randomized scoreboard bench for blit_src_reader: a rectangle-walking reference model fills
// expected request/pixel queues; a responder models in-order memory; a monitor pops and compares.
module tb_blit_src_reader;
  localparam int ADDR_W = 26, DIM_W = 11, STRIDE_W = 16, FIFO_DEPTH = 4;

  logic clock, reset_n, start, textmode, busy, done, mem_req, mem_ack, mem_rvalid;
  logic stall, out_valid, out_last;
  logic [ADDR_W-1:0]   src_addr, mem_addr;
  logic [STRIDE_W-1:0] src_stride;
  logic [DIM_W-1:0]    width, height;
  logic [7:0]          mem_rdata, src_data;
  logic [2:0]          src_bit;

  typedef struct packed { logic [7:0] data; logic [2:0] bitn; logic last; } pix_t;
  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] due; } rd_t;

  pix_t              exp_pix[$];
  logic [ADDR_W-1:0] exp_addr[$];
  rd_t               rq[$];
  logic [7:0]        mem_img [logic [ADDR_W-1:0]];

  int n_checks, n_passed, lat, ack_pct, pixels_seen;
  bit force_stall, rand_stall, zero_start, expect_done_next, done_seen;
  logic [31:0] cyc;

  blit_src_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .src_addr(src_addr),
    .src_stride(src_stride), .width(width), .height(height), .textmode(textmode),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall), .out_valid(out_valid),
    .src_data(src_data), .src_bit(src_bit), .out_last(out_last)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input bit ok, input logic [31:0] act,
                              input logic [31:0] req);
    n_checks++;
    if (ok) n_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    if (!mem_img.exists(a)) mem_img[a] = 8'($urandom);
    return mem_img[a];
  endfunction

  // Reference model: raster walk of the rectangle in plain arithmetic
  task automatic build_expect(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] stride,
                              input int w, input int h, input bit tm);
    logic [ADDR_W-1:0] rb;
    pix_t p;
    int nb;
    nb = tm ? (w + 7) / 8 : w;
    for (int y = 0; y < h; y++) begin
      rb = base + ADDR_W'(y) * ADDR_W'(stride);
      for (int b = 0; b < nb; b++) exp_addr.push_back(rb + ADDR_W'(b));
      for (int x = 0; x < w; x++) begin
        p.data = mem_byte(rb + ADDR_W'(tm ? x / 8 : x));
        p.bitn = tm ? 3'(7 - x % 8) : 3'd0;
        p.last = (x == w - 1) && (y == h - 1);
        exp_pix.push_back(p);
      end
    end
  endtask

  // In-order memory with configurable latency and random acceptance
  initial begin
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; cyc = '0;
    forever begin
      @(negedge clock);
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_byte(rq[0].addr);
        void'(rq.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 8'($urandom);
      end
      mem_ack = reset_n && mem_req && ($urandom_range(99) < ack_pct);
      if (mem_ack) begin
        rq.push_back('{addr: mem_addr, due: cyc + 32'(lat)});
        check_output("inflight_limit", rq.size() <= FIFO_DEPTH, 32'(rq.size()), 32'(FIFO_DEPTH));
      end
      cyc++;
    end
  end

  initial begin
    stall = 1'b0;
    forever begin
      @(negedge clock);
      stall = force_stall || (rand_stall && $urandom_range(3) == 0);
    end
  end

  // Monitor: samples one time unit after the falling edge
  initial begin
    pix_t e;
    logic [11:0] got;
    logic [12:0] prev_vec, cur_vec;
    bit prev_ok, prev_stall;
    prev_ok = 1'b0; prev_stall = 1'b0; prev_vec = '0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset_n) begin
        prev_ok = 1'b0;
        continue;
      end
      if (expect_done_next) begin
        check_output("done_pulse", done == 1'b1, 32'(done), 1);
        check_output("busy_fall", busy == 1'b0, 32'(busy), 0);
        expect_done_next = 1'b0;
        done_seen = 1'b1;
      end else if (done) begin
        check_output("spurious_done", done == 1'b0, 32'(done), 0);
      end
      if (zero_start) begin
        check_output("zero_busy", busy == 1'b1, 32'(busy), 1);
        zero_start = 1'b0;
        expect_done_next = 1'b1;
      end
      cur_vec = {out_valid, src_data, src_bit, out_last};
      if (prev_ok && prev_stall)
        check_output("stall_freeze", cur_vec == prev_vec, 32'(cur_vec), 32'(prev_vec));
      if (mem_req && mem_ack) begin
        if (exp_addr.size() == 0)
          check_output("extra_request", 1'b0, 32'(mem_addr), 0);
        else
          check_output("req_addr", mem_addr == exp_addr[0], 32'(mem_addr), 32'(exp_addr[0]));
        if (exp_addr.size() > 0) void'(exp_addr.pop_front());
      end
      if (out_valid && !stall) begin
        pixels_seen++;
        got = {src_data, src_bit, out_last};
        if (exp_pix.size() == 0) begin
          check_output("extra_pixel", 1'b0, 32'(got), 0);
        end else begin
          e = exp_pix.pop_front();
          check_output("pixel", got == e, 32'(got), 32'(e));
          if (e.last) expect_done_next = 1'b1;
        end
      end
      prev_vec = cur_vec;
      prev_stall = stall;
      prev_ok = 1'b1;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_busy"}, busy == 1'b0, 32'(busy), 0);
    check_output({tag, "_done"}, done == 1'b0, 32'(done), 0);
    check_output({tag, "_mem_req"}, mem_req == 1'b0, 32'(mem_req), 0);
    check_output({tag, "_mem_addr"}, mem_addr == '0, 32'(mem_addr), 0);
    check_output({tag, "_out_valid"}, out_valid == 1'b0, 32'(out_valid), 0);
    check_output({tag, "_src_data"}, src_data == '0, 32'(src_data), 0);
    check_output({tag, "_src_bit"}, src_bit == '0, 32'(src_bit), 0);
    check_output({tag, "_out_last"}, out_last == 1'b0, 32'(out_last), 0);
  endtask

  task automatic apply_stimulus(input logic [ADDR_W-1:0] base, input logic [STRIDE_W-1:0] stride,
                                input int w, input int h, input bit tm, input bit dup,
                                input int stall_at);
    bit stalled;
    int hold;
    stalled = 1'b0; hold = 0;
    build_expect(base, stride, w, h, tm);
    done_seen = 1'b0;
    pixels_seen = 0;
    @(negedge clock);
    start = 1'b1; src_addr = base; src_stride = stride;
    width = DIM_W'(w); height = DIM_W'(h); textmode = tm;
    @(negedge clock);
    start = 1'b0;
    src_addr = ADDR_W'($urandom); src_stride = STRIDE_W'($urandom);
    width = DIM_W'($urandom); height = DIM_W'($urandom); textmode = 1'($urandom);
    if (w == 0 || h == 0) zero_start = 1'b1;
    for (int i = 0; i < 4000 && !done_seen; i++) begin
      @(negedge clock);
      start = dup && (i == 2);
      if (stall_at >= 0 && !stalled && pixels_seen >= stall_at) begin
        stalled = 1'b1; force_stall = 1'b1; hold = 5;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) force_stall = 1'b0;
      end
    end
    start = 1'b0;
    force_stall = 1'b0;
    check_output("run_done", done_seen, 32'(done_seen), 1);
    check_output("pixels_drained", exp_pix.size() == 0, 32'(exp_pix.size()), 0);
    check_output("reqs_drained", exp_addr.size() == 0, 32'(exp_addr.size()), 0);
    exp_pix.delete();
    exp_addr.delete();
    @(negedge clock);
  endtask

  task automatic reset_mid_fetch();
    int waited;
    lat = 6; ack_pct = 100;
    build_expect(26'h0007000, 16'h0100, 16, 2, 1'b0);
    @(negedge clock);
    start = 1'b1; src_addr = 26'h0007000; src_stride = 16'h0100;
    width = DIM_W'(16); height = DIM_W'(2); textmode = 1'b0;
    @(negedge clock);
    start = 1'b0;
    waited = 0;
    while (rq.size() < 2 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check_output("outstanding_before_reset", rq.size() >= 2, 32'(rq.size()), 2);
    reset_n = 1'b0;
    exp_pix.delete(); exp_addr.delete();
    expect_done_next = 1'b0; zero_start = 1'b0;
    @(negedge clock);
    #1 check_idle_outputs("midreset");
    @(negedge clock);
    reset_n = 1'b1;
    waited = 0;
    while (rq.size() > 0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    repeat (2) @(negedge clock);
    #1;
    check_output("stale_drained", rq.size() == 0, 32'(rq.size()), 0);
    check_output("stale_out_valid", out_valid == 1'b0, 32'(out_valid), 0);
    check_output("stale_busy", busy == 1'b0, 32'(busy), 0);
    check_output("stale_mem_req", mem_req == 1'b0, 32'(mem_req), 0);
  endtask

  initial begin
    n_checks = 0; n_passed = 0; lat = 1; ack_pct = 100; pixels_seen = 0;
    force_stall = 1'b0; rand_stall = 1'b0; zero_start = 1'b0;
    expect_done_next = 1'b0; done_seen = 1'b0;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; src_stride = '0;
    width = '0; height = '0; textmode = 1'b0;
    repeat (3) @(negedge clock);
    #1 check_idle_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] byte mode 3x2, stride 0x40, 1-cycle memory");
    apply_stimulus(26'h0000100, 16'h0040, 3, 2, 1'b0, 1'b0, -1);

    $display("[TB] text mode w=10 h=1, bytes A5 C0");
    mem_img[26'h0002000] = 8'hA5;
    mem_img[26'h0002001] = 8'hC0;
    apply_stimulus(26'h0002000, 16'h0100, 10, 1, 1'b1, 1'b0, -1);

    $display("[TB] latency 6");
    lat = 6;
    apply_stimulus(26'h0010000, 16'h0080, 9, 3, 1'b0, 1'b0, -1);
    apply_stimulus(26'h0011000, 16'h0020, 19, 2, 1'b1, 1'b0, -1);

    $display("[TB] five-cycle stall mid-row");
    lat = 1;
    apply_stimulus(26'h0003000, 16'h0020, 12, 2, 1'b0, 1'b0, 5);

    $display("[TB] zero-size starts");
    apply_stimulus(26'h0004000, 16'h0010, 5, 0, 1'b0, 1'b0, -1);
    apply_stimulus(26'h0004000, 16'h0010, 0, 3, 1'b1, 1'b0, -1);

    $display("[TB] start while busy");
    apply_stimulus(26'h0005000, 16'h0040, 16, 2, 1'b0, 1'b1, -1);

    $display("[TB] address wrap");
    apply_stimulus(26'h3FFFFFE, 16'hFFFF, 4, 3, 1'b0, 1'b0, -1);

    $display("[TB] randomized rectangles");
    rand_stall = 1'b1;
    for (int r = 0; r < 10; r++) begin
      lat = int'($urandom_range(1, 6));
      ack_pct = int'($urandom_range(40, 100));
      apply_stimulus(ADDR_W'($urandom), STRIDE_W'($urandom), int'($urandom_range(1, 20)),
                     int'($urandom_range(1, 4)), 1'($urandom_range(1)), 1'b0, -1);
    end
    rand_stall = 1'b0;
    ack_pct = 100;

    $display("[TB] reset mid-fetch, then fresh start");
    reset_mid_fetch();
    lat = 2;
    apply_stimulus(26'h0006000, 16'h0030, 7, 2, 1'b1, 1'b0, -1);

    $display("[TB] %0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
